// File: rtl/jtdd2_shared_arb.sv
// Shared-RAM ownership arbiter for the DD2 main CPU and sub Z80.
// Sequences the sub bus request/acknowledge handshake, flags a sub that never
// acknowledges, and muxes both CPUs onto a single registered RAM port.
module jtdd2_shared_arb #(
   parameter int unsigned AW   = 10,
   parameter int unsigned TOUT = 255
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          cen,
   input  logic          main_cen,
   input  logic          main_halt,
   input  logic          main_cs,
   input  logic          main_wrn,
   input  logic [8:0]    main_addr,
   input  logic [7:0]    main_dout,
   input  logic          sub_busak_n,
   output logic          sub_busrq_n,
   input  logic          sub_cs,
   input  logic          sub_rnw,
   input  logic [AW-1:0] sub_addr,
   input  logic [7:0]    sub_dout,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_din,
   output logic          ram_we,
   output logic          owner,
   output logic          timeout
);

   typedef enum logic [1:0] {
      StSub  = 2'd0,
      StReq  = 2'd1,
      StMain = 2'd2,
      StRel  = 2'd3
   } state_t;

   localparam logic [7:0] TOUT8 = 8'(TOUT);

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
   logic            busrq_n_q, busrq_n_d;
   logic            owner_q, owner_d;
   logic            prev_wrn_q;
   logic            ram_we_q, ram_we_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]      ram_din_q, ram_din_d;
   logic [AW-1:0]   main_addr_ext;
   logic            main_we, sub_we;

   assign main_addr_ext = AW'(main_addr);

   // Handshake FSM next state plus the REQ-state acknowledge timeout counter
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      if (cen) begin
         unique case (state_q)
            StSub:  if (main_halt) state_d = StReq;
            // Abort wins over a simultaneous acknowledge
            StReq: begin
               if (!main_halt)        state_d = StSub;
               else if (!sub_busak_n) state_d = StMain;
            end
            StMain: if (!main_halt) state_d = StRel;
            // A re-request during release goes straight back to REQ
            StRel: begin
               if (main_halt)        state_d = StReq;
               else if (sub_busak_n) state_d = StSub;
            end
            default: state_d = StSub;
         endcase

         if (state_q == StReq) begin
            if (cnt_q != TOUT8) cnt_d = cnt_q + 8'd1;
            if (cnt_d == TOUT8) timeout_d = 1'b1;
         end else if (state_d == StReq) begin
            cnt_d     = 8'd0;
            timeout_d = 1'b0;
         end
      end
   end

   // Registered decodes of the next state
   always_comb begin
      busrq_n_d = !((state_d == StReq) || (state_d == StMain));
      owner_d   = (state_d == StMain);
   end

   // Write qualification and RAM port mux; the bus stays the sub's until acknowledge
   always_comb begin
      main_we = prev_wrn_q && !main_wrn && main_cs && main_cen && (state_q == StMain);
      sub_we  = sub_cs && !sub_rnw && cen && ((state_q == StSub) || (state_q == StReq));
      ram_we_d   = main_we || sub_we;
      ram_din_d  = ram_din_q;
      ram_addr_d = (state_q == StMain) ? main_addr_ext : sub_addr;
      if (main_we) begin
         ram_addr_d = main_addr_ext;
         ram_din_d  = main_dout;
      end else if (sub_we) begin
         ram_addr_d = sub_addr;
         ram_din_d  = sub_dout;
      end
   end

   // State, handshake outputs and RAM port registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StSub;
         cnt_q      <= 8'd0;
         timeout_q  <= 1'b0;
         busrq_n_q  <= 1'b1;
         owner_q    <= 1'b0;
         prev_wrn_q <= 1'b1;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         busrq_n_q  <= busrq_n_d;
         owner_q    <= owner_d;
         prev_wrn_q <= main_wrn;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   assign sub_busrq_n = busrq_n_q;
   assign owner       = owner_q;
   assign timeout     = timeout_q;
   assign ram_we      = ram_we_q;
   assign ram_addr    = ram_addr_q;
   assign ram_din     = ram_din_q;

endmodule

// File: tb/tb_jtdd2_shared_arb.sv
// Bench for jtdd2_shared_arb: directed handshake scenarios followed by random
// traffic, all compared against a behavioural model of the ownership rules.
module tb_jtdd2_shared_arb;

   localparam int AW   = 10;
   localparam int TOUT = 4;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cen, main_cen, main_halt, main_cs, main_wrn;
   logic [8:0]    main_addr;
   logic [7:0]    main_dout;
   logic          sub_busak_n, sub_busrq_n, sub_cs, sub_rnw;
   logic [AW-1:0] sub_addr;
   logic [7:0]    sub_dout;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic          ram_we, owner, timeout;

   int tests_run    = 0;
   int tests_failed = 0;

   // Model: who holds the bus, named as text for readability
   string m_st;
   int    m_cnt;
   bit    m_to, m_prev_wrn, m_we;
   int    m_addr, m_din;

   jtdd2_shared_arb #(.AW(AW), .TOUT(TOUT)) dut (
      .clk(clk), .rstn(rstn), .cen(cen), .main_cen(main_cen), .main_halt(main_halt),
      .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr), .main_dout(main_dout),
      .sub_busak_n(sub_busak_n), .sub_busrq_n(sub_busrq_n), .sub_cs(sub_cs),
      .sub_rnw(sub_rnw), .sub_addr(sub_addr), .sub_dout(sub_dout), .ram_addr(ram_addr),
      .ram_din(ram_din), .ram_we(ram_we), .owner(owner), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = "SUB"; m_cnt = 0; m_to = 0; m_prev_wrn = 1; m_we = 0; m_addr = 0; m_din = 0;
   endtask

   function automatic bit m_busrq_n();
      return !(m_st == "REQ" || m_st == "MAIN");
   endfunction

   // One clk edge: advance the model from the inputs the DUT saw, then compare
   task automatic tick();
      bit    mwe, swe;
      string nxt;
      @(posedge clk);
      mwe = m_prev_wrn && !main_wrn && main_cs && main_cen && m_st == "MAIN";
      swe = sub_cs && !sub_rnw && cen && (m_st == "SUB" || m_st == "REQ");
      m_we = mwe || swe;
      if (mwe) begin
         m_addr = int'(main_addr); m_din = int'(main_dout);
      end else if (swe) begin
         m_addr = int'(sub_addr); m_din = int'(sub_dout);
      end else begin
         m_addr = (m_st == "MAIN") ? int'(main_addr) : int'(sub_addr);
      end
      m_prev_wrn = main_wrn;
      if (cen) begin
         nxt = m_st;
         if (m_st == "SUB" && main_halt) nxt = "REQ";
         else if (m_st == "REQ") nxt = !main_halt ? "SUB" : (!sub_busak_n ? "MAIN" : "REQ");
         else if (m_st == "MAIN" && !main_halt) nxt = "REL";
         else if (m_st == "REL") nxt = main_halt ? "REQ" : (sub_busak_n ? "SUB" : "REL");
         if (m_st == "REQ") begin
            if (m_cnt < TOUT) m_cnt++;
            if (m_cnt == TOUT) m_to = 1;
         end else if (nxt == "REQ") begin
            m_cnt = 0; m_to = 0;
         end
         m_st = nxt;
      end
      #1;
      check("busrq_n", int'(sub_busrq_n), int'(m_busrq_n()));
      check("owner", int'(owner), int'(m_st == "MAIN"));
      check("timeout", int'(timeout), int'(m_to));
      check("ram_we", int'(ram_we), int'(m_we));
      check("ram_addr", int'(ram_addr), m_addr);
      if (m_we) check("ram_din", int'(ram_din), m_din);
   endtask

   task automatic idle_inputs();
      cen = 1; main_cen = 1; main_cs = 0; main_wrn = 1; sub_cs = 0; sub_rnw = 1;
   endtask

   initial begin
      rstn = 0; main_halt = 0; sub_busak_n = 1; main_addr = 0; main_dout = 0;
      sub_addr = 0; sub_dout = 0;
      idle_inputs();
      model_reset();
      #12;
      check("rst_busrq_n", int'(sub_busrq_n), 1);
      check("rst_owner", int'(owner), 0);
      check("rst_timeout", int'(timeout), 0);
      check("rst_ram_we", int'(ram_we), 0);
      check("rst_ram_addr", int'(ram_addr), 0);
      check("rst_ram_din", int'(ram_din), 0);
      rstn = 1;
      tick();

      // Sub write while idle
      sub_cs = 1; sub_rnw = 0; sub_addr = 10'h123; sub_dout = 8'h5A;
      tick();
      check("sub_we", int'(ram_we), 1);
      check("sub_addr", int'(ram_addr), 'h123);
      check("sub_din", int'(ram_din), 'h5A);
      sub_cs = 0; sub_rnw = 1;
      tick();
      check("sub_we_1clk", int'(ram_we), 0);

      // Main write outside MAIN is dropped
      main_cs = 1; main_addr = 9'h0AA; main_dout = 8'h33; main_wrn = 1;
      tick();
      main_wrn = 0;
      tick();
      tick();
      check("main_drop", int'(ram_we), 0);
      idle_inputs();

      // Full handshake
      main_halt = 1;
      tick();
      check("hs_busrq", int'(sub_busrq_n), 0);
      check("hs_owner0", int'(owner), 0);
      sub_busak_n = 0;
      tick();
      check("hs_owner1", int'(owner), 1);
      main_cs = 1; main_addr = 9'h0FF; main_dout = 8'hA5;
      tick();
      main_wrn = 0;
      tick();
      check("main_we", int'(ram_we), 1);
      check("main_addr", int'(ram_addr), 'h0FF);
      check("main_din", int'(ram_din), 'hA5);
      tick();
      check("main_we_1clk", int'(ram_we), 0);
      idle_inputs();
      main_halt = 0;
      tick();
      check("rel_busrq", int'(sub_busrq_n), 1);
      check("rel_owner", int'(owner), 0);
      sub_busak_n = 1;
      tick();
      check("back_sub", int'(sub_busrq_n), 1);

      // Timeout with TOUT=4
      main_halt = 1;
      tick();
      for (int i = 0; i < 3; i++) tick();
      check("to_early", int'(timeout), 0);
      tick();
      check("to_set", int'(timeout), 1);
      sub_busak_n = 0;
      tick();
      check("to_main", int'(owner), 1);
      check("to_sticky", int'(timeout), 1);
      main_halt = 0;
      tick();
      sub_busak_n = 1;
      tick();
      main_halt = 1;
      tick();
      check("to_clear", int'(timeout), 0);

      // Abort: halt drops with acknowledge on the same tick
      main_halt = 0; sub_busak_n = 0;
      tick();
      check("abort_owner", int'(owner), 0);
      check("abort_busrq", int'(sub_busrq_n), 1);
      sub_busak_n = 1;
      tick();

      // Asynchronous reset while in MAIN
      main_halt = 1;
      tick();
      sub_busak_n = 0;
      tick();
      check("pre_rst_owner", int'(owner), 1);
      #2 rstn = 0;
      #1;
      check("arst_busrq", int'(sub_busrq_n), 1);
      check("arst_owner", int'(owner), 0);
      model_reset();
      #1 rstn = 1;
      main_halt = 0; sub_busak_n = 1;
      tick();

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cen = ($urandom_range(0, 2) == 0);
         main_cen = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 11) == 0) main_halt = ~main_halt;
         if ($urandom_range(0, 3) == 0) sub_busak_n = m_busrq_n();
         else if ($urandom_range(0, 19) == 0) sub_busak_n = ~sub_busak_n;
         main_cs = $urandom_range(0, 1) == 1;
         main_wrn = $urandom_range(0, 2) != 0;
         main_addr = 9'($urandom);
         main_dout = 8'($urandom);
         sub_cs = $urandom_range(0, 1) == 1;
         sub_rnw = $urandom_range(0, 1) == 1;
         sub_addr = AW'($urandom);
         sub_dout = 8'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/jtdd2_shared_arb.md
# jtdd2_shared_arb

Bus-ownership controller for the 1 kB shared RAM that sits between the Double Dragon 2 main CPU and the sub Z80. It sequences the halt handshake: it drives the sub CPU bus request, waits for bus acknowledge, grants the RAM to the main CPU, and hands it back. It also generates the single-cycle write strobes and the address/data mux for a single-port RAM. It replaces the ad-hoc edge logic around the dual-port RAM so the shared memory can map onto one block RAM port.

## Interface
Parameters:
- AW, 10, RAM address width.
- TOUT, 255, sub `cen` ticks to wait in REQ before raising `timeout`. Valid range 1..255; the counter is 8 bits.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- cen  in  1  sub CPU clock enable; FSM transitions and sub writes qualify on it.
- main_cen  in  1  main CPU clock enable.
- main_halt  in  1  level from the main CPU latch; 1 = main wants sub halted.
- main_cs  in  1  main CPU selects shared RAM.
- main_wrn  in  1  main CPU write strobe, active low.
- main_addr  in  9  main CPU address.
- main_dout  in  8  main CPU write data.
- sub_busak_n  in  1  sub Z80 bus acknowledge, active low.
- sub_busrq_n  out  1  sub Z80 bus request, active low.
- sub_cs  in  1  sub CPU selects shared RAM.
- sub_rnw  in  1  sub CPU read/not-write.
- sub_addr  in  AW  sub CPU address.
- sub_dout  in  8  sub CPU write data.
- ram_addr  out  AW  RAM address, registered.
- ram_din  out  8  RAM write data, registered.
- ram_we  out  1  RAM write enable, registered, one clk wide.
- owner  out  1  0 = sub owns RAM, 1 = main owns RAM.
- timeout  out  1  sticky; the sub failed to acknowledge within TOUT.

## Operation
- FSM states: SUB (reset state), REQ, MAIN, REL. State changes only on clk edges where `cen`=1.
- SUB -> REQ when `main_halt`=1.
- REQ -> MAIN when `sub_busak_n`=0.
- REQ -> SUB when `main_halt`=0 (abort). The abort has priority over acknowledge in the same tick.
- MAIN -> REL when `main_halt`=0.
- REL -> SUB when `sub_busak_n`=1.
- REL -> REQ when `main_halt` returns to 1 before the release completes.
- `sub_busrq_n` = 0 in REQ and MAIN, 1 in SUB and REL. It is a registered state decode.
- `owner` = 1 only in MAIN.
- Timeout counter: 8 bits, cleared on entry to REQ, increments on each `cen` tick in REQ and saturates at TOUT.
  - Reaching TOUT sets `timeout`. The FSM stays in REQ.
  - `timeout` clears on the next entry to REQ, or on reset.
- Main write detect: `main_wrn` falls (previous value 1, current 0) while `main_cs`=1 and `main_cen`=1, with the FSM in MAIN.
  - Effect: `ram_we`=1 next clk, with `ram_addr`={0,main_addr} and `ram_din`=main_dout.
  - A main write outside MAIN is dropped and never queued.
- Sub write: `sub_cs`=1, `sub_rnw`=0, `cen`=1, with the FSM in SUB or REQ (the bus is still the sub's until acknowledge).
  - Effect: `ram_we`=1 next clk, with `ram_addr`=sub_addr and `ram_din`=sub_dout.
- No write is issued in REL.
- Without a write, `ram_addr` follows the owner's address each clk: main in MAIN, sub otherwise. `ram_we`=0.
- Simultaneous events:
  - Main and sub write qualifiers cannot both be valid, because their ownership states are disjoint.
  - A sub write on the same tick as SUB->REQ is honoured.
- The previous-`main_wrn` register samples every clk, not only on `main_cen`.

## Timing
- Reset values: FSM=SUB, `sub_busrq_n`=1, `owner`=0, `timeout`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, counter=0, previous `main_wrn`=1.
- Reset mid-handshake returns to SUB immediately and releases `sub_busrq_n` asynchronously. Any pending write is lost.
- Halt latency: `main_halt` rising -> `sub_busrq_n` low at the end of the next `cen` tick (1 tick).
- Grant latency: `sub_busak_n` low -> `owner`=1 one `cen` tick later.
- Release latency: `main_halt` falling -> `sub_busrq_n` high after 1 tick; `owner` drops in the same tick.
- Write latency: qualifying edge -> `ram_we` high exactly 1 clk later, for 1 clk.
- Read data from a registered-address RAM is valid 2 clk after the address changes; both CPUs tolerate this at `cen` rates of clk/4 or slower.

## Test plan
- Reset then idle: `sub_busrq_n`=1, `owner`=0; a sub write of 0x5A to 0x123 gives `ram_we` for 1 clk with addr 0x123, data 0x5A.
- Full handshake:
  - `main_halt`=1 -> `sub_busrq_n`=0 after 1 `cen` tick.
  - Assert `sub_busak_n`=0 -> `owner`=1.
  - Main write of 0xA5 at 0x0FF -> `ram_we` pulse with addr 0x0FF, data 0xA5.
  - `main_halt`=0, then `busak_n`=1 -> SUB.
- Main write while `owner`=0: `ram_we` stays 0, RAM unchanged.
- Timeout: hold `main_halt`=1 and `busak_n`=1 for TOUT=4 ticks -> `timeout`=1 on the 4th tick; a later acknowledge reaches MAIN and `timeout` stays 1 until the next REQ entry.
- Abort: `main_halt` 1 then 0 while in REQ, with `busak_n` going low in the same tick -> FSM returns to SUB, `owner` never rises.
- Assert `rstn`=0 while in MAIN -> `sub_busrq_n`=1 and `owner`=0 with no clock edge.
